// File: rtl/data_memory_arbiter_if.sv
// Requester and memory-side signals of the two-port data memory arbiter.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface data_memory_arbiter_if #(
    parameter int byte_W = 4,
    parameter int Addr_W = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [Addr_W-1:0]     addr0;
    logic [Addr_W-1:0]     addr1;
    logic [8*byte_W-1:0]   wdata0;
    logic [8*byte_W-1:0]   wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  ack0;
    logic                  ack1;
    logic [8*byte_W-1:0]   rdata0;
    logic [8*byte_W-1:0]   rdata1;
    logic                  busy;
    logic [Addr_W-1:0]     mem_address;
    logic [8*byte_W-1:0]   mem_write_data;
    logic                  mem_write_enable;
    logic [8*byte_W-1:0]   mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy,
               mem_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy,
               mem_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin two-port sequencer for a shared memory: grant in IDLE, access next cycle,
// ack/rdata the cycle after; requests are held off (no grant) while in ACCESS.
module data_memory_arbiter #(
    parameter int byte_W = 4,
    parameter int Addr_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    data_memory_arbiter_if.slave   bus
);
    localparam int DATA_W = 8 * byte_W;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic                r_owner;
    logic                r_we;
    logic [Addr_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_ack0;
    logic                r_ack1;
    logic                w_pick1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_access;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_gnt0 || w_gnt1) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Under contention the port that did not win last time takes the grant.
    always_comb begin
        w_pick1  = bus.req1 & (~bus.req0 | ~r_last_grant);
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        w_access = (r_state == S_ACCESS);
        if ((r_state == S_IDLE) && !i_reset) begin
            w_gnt1 = w_pick1;
            w_gnt0 = bus.req0 & ~w_pick1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_gnt0 || w_gnt1) begin
                r_owner      <= w_gnt1;
                r_last_grant <= w_gnt1;
                r_we         <= w_gnt1 ? bus.we1    : bus.we0;
                r_addr       <= w_gnt1 ? bus.addr1  : bus.addr0;
                r_wdata      <= w_gnt1 ? bus.wdata1 : bus.wdata0;
            end
            if (w_access) begin
                if (r_owner) begin
                    r_ack1 <= 1'b1;
                    if (!r_we) r_rdata1 <= bus.mem_read_data;
                end else begin
                    r_ack0 <= 1'b1;
                    if (!r_we) r_rdata0 <= bus.mem_read_data;
                end
            end
        end
    end

    assign bus.gnt0             = w_gnt0;
    assign bus.gnt1             = w_gnt1;
    assign bus.ack0             = r_ack0;
    assign bus.ack1             = r_ack1;
    assign bus.rdata0           = r_rdata0;
    assign bus.rdata1           = r_rdata1;
    assign bus.busy             = w_access;
    assign bus.mem_address      = r_addr;
    assign bus.mem_write_data   = r_wdata;
    // Reset in the access cycle must not let the write reach memory.
    assign bus.mem_write_enable = w_access & r_we & ~i_reset;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed cycle table, then random traffic vs a transaction model.
module tb_data_memory_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic preload;
    logic [7:0] mem [256];

    data_memory_arbiter_if #(.byte_W(4), .Addr_W(8)) ifc();
    data_memory_arbiter #(.byte_W(4), .Addr_W(8)) dut (.i_clk(clk), .i_reset(reset), .bus(ifc.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h07;
            mem[4] <= 8'h08;
        end else if (ifc.mem_write_enable) begin
            for (int i = 0; i < 4; i++) mem[ifc.mem_address + 8'(i)] <= ifc.mem_write_data[8*i +: 8];
        end
    end

    always_comb begin
        ifc.mem_read_data = '0;
        for (int i = 0; i < 4; i++) ifc.mem_read_data[8*i +: 8] = mem[ifc.mem_address + 8'(i)];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic [7:0] a0, input logic [7:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        reset = rst; ifc.req0 = r0; ifc.req1 = r1; ifc.we0 = w0; ifc.we1 = w1;
        ifc.addr0 = a0; ifc.addr1 = a1; ifc.wdata0 = d0; ifc.wdata1 = d1;
    endtask

    typedef struct {
        logic rst, r0, r1, w0, w1;
        logic [7:0] a0, a1;
        logic [31:0] d0, d1;
        logic g0, g1, bsy, mwe, k0, k1;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic r0, logic r1, logic w0, logic w1, logic [7:0] a0, logic [7:0] a1,
                                logic [31:0] d0, logic [31:0] d1, logic g0, logic g1, logic bsy, logic mwe,
                                logic k0, logic k1, logic [31:0] rd0, logic [31:0] rd1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.bsy = bsy; v.mwe = mwe; v.k0 = k0; v.k1 = k1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[a + 8'(i)];
        return w;
    endfunction

    // Transaction-level reference: pending access, per-port completion, byte-array memory.
    logic [7:0]  ref_mem [256];
    int          m_last;
    bit          m_acc_v, m_acc_own, m_acc_we;
    logic [7:0]  m_acc_addr;
    logic [31:0] m_acc_wd;
    bit          m_ack0, m_ack1;
    logic [31:0] m_rd0, m_rd1;

    initial begin
        bit rst, r0, r1, w0, w1, eg0, eg1, n0, n1, win;
        logic [7:0] a0, a1;
        logic [31:0] d0, d1, rv;

        preload = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;

        //          rst r0 r1 w0 w1 a0 a1 d0            d1            g0 g1 bsy mwe k0 k1 rd0           rd1
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4, 0, 0,            0,            1, 0, 0, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 1, 0, 8,            0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 8, 0,            32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 8,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 1, 0, 0, 8,            0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8, 0, 0,            0,            1, 0, 0, 0, 0, 1, 8,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0, 8,            0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 1, 0, 0, 1, 0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4, 0,            0,            1, 0, 0, 0, 0, 1, 32'hDEADBEEF, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 1, 0, 7,            8));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 4, 0,            0,            0, 0, 0, 0, 0, 0, 7,            8));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            1, 0, 0, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 0, 1, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 1, 0, 0, 1, 0, 7,            0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 0, 1, 0, 0, 0, 7,            0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            1, 0, 0, 0, 0, 1, 7,            8));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 0, 1, 0, 0, 0, 7,            8));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 1, 0, 0, 1, 0, 7,            8));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            0, 0, 1, 0, 0, 0, 7,            8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 1, 7,            8));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 32'h11223344, 0,            1, 0, 0, 0, 0, 0, 7,            8));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0, 7,            8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 0,            0,            1, 0, 0, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0, 0,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 1, 0, 7,            0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 2, 0, 32'hAABBCCDD, 0,            1, 0, 0, 0, 0, 0, 7,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 1, 0, 0, 7,            0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,            0,            1, 0, 0, 0, 1, 0, 7,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 1, 0, 0, 0, 7,            0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,            0,            0, 0, 0, 0, 1, 0, 32'hCCDD0007, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            if (i > 0) @(negedge clk);
            drive(v.rst, v.r0, v.r1, v.w0, v.w1, v.a0, v.a1, v.d0, v.d1);
            #1;
            chk($sformatf("vec%0d_gnt0", i),  32'(ifc.gnt0), 32'(v.g0));
            chk($sformatf("vec%0d_gnt1", i),  32'(ifc.gnt1), 32'(v.g1));
            chk($sformatf("vec%0d_busy", i),  32'(ifc.busy), 32'(v.bsy));
            chk($sformatf("vec%0d_mwe", i),   32'(ifc.mem_write_enable), 32'(v.mwe));
            chk($sformatf("vec%0d_ack0", i),  32'(ifc.ack0), 32'(v.k0));
            chk($sformatf("vec%0d_ack1", i),  32'(ifc.ack1), 32'(v.k1));
            chk($sformatf("vec%0d_rdata0", i), ifc.rdata0, v.rd0);
            chk($sformatf("vec%0d_rdata1", i), ifc.rdata1, v.rd1);
            if (i == 25) chk("reset_write_suppressed_mem0", mem_word(8'd0), 32'h00000007);
        end
        chk("mem_byte8",  32'(mem[8]),  32'hEF);
        chk("mem_byte9",  32'(mem[9]),  32'hBE);
        chk("mem_byte10", 32'(mem[10]), 32'hAD);
        chk("mem_byte11", 32'(mem[11]), 32'hDE);
        chk("unaligned_mem4", mem_word(8'd4), 32'h0000AABB);

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        m_last = 1; m_acc_v = 0; m_acc_own = 0; m_acc_we = 0; m_acc_addr = 0; m_acc_wd = 0;
        m_ack0 = 0; m_ack1 = 0; m_rd0 = 0; m_rd1 = 0;

        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            rst = ($urandom_range(0, 60) == 0);
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            w0 = $urandom_range(0, 1) != 0;
            w1 = $urandom_range(0, 1) != 0;
            a0 = 8'($urandom_range(0, 31));
            a1 = 8'($urandom_range(0, 31));
            d0 = $urandom;
            d1 = $urandom;
            drive(rst, r0, r1, w0, w1, a0, a1, d0, d1);
            #1;
            eg0 = 0; eg1 = 0;
            if (!rst && !m_acc_v && (r0 || r1)) begin
                win = (r0 && r1) ? (m_last == 0) : r1;
                eg0 = !win;
                eg1 = win;
            end
            chk("rnd_gnt0", 32'(ifc.gnt0), 32'(eg0));
            chk("rnd_gnt1", 32'(ifc.gnt1), 32'(eg1));
            chk("rnd_busy", 32'(ifc.busy), 32'(m_acc_v));
            chk("rnd_mwe",  32'(ifc.mem_write_enable), 32'(m_acc_v && m_acc_we && !rst));
            chk("rnd_ack0", 32'(ifc.ack0), 32'(m_ack0));
            chk("rnd_ack1", 32'(ifc.ack1), 32'(m_ack1));
            chk("rnd_rdata0", ifc.rdata0, m_rd0);
            chk("rnd_rdata1", ifc.rdata1, m_rd1);
            if (m_acc_v) begin
                chk("rnd_maddr",  32'(ifc.mem_address), 32'(m_acc_addr));
                chk("rnd_mwdata", ifc.mem_write_data, m_acc_wd);
            end

            if (rst) begin
                m_last = 1; m_acc_v = 0; m_ack0 = 0; m_ack1 = 0; m_rd0 = 0; m_rd1 = 0;
            end else begin
                n0 = 0; n1 = 0;
                if (m_acc_v) begin
                    if (m_acc_we) begin
                        for (int b = 0; b < 4; b++) ref_mem[m_acc_addr + 8'(b)] = m_acc_wd[8*b +: 8];
                    end else begin
                        for (int b = 0; b < 4; b++) rv[8*b +: 8] = ref_mem[m_acc_addr + 8'(b)];
                        if (m_acc_own) m_rd1 = rv; else m_rd0 = rv;
                    end
                    if (m_acc_own) n1 = 1; else n0 = 1;
                    m_acc_v = 0;
                end
                if (eg0 || eg1) begin
                    m_acc_v    = 1;
                    m_acc_own  = eg1;
                    m_acc_we   = eg1 ? w1 : w0;
                    m_acc_addr = eg1 ? a1 : a0;
                    m_acc_wd   = eg1 ? d1 : d0;
                    m_last     = eg1 ? 1 : 0;
                end
                m_ack0 = n0;
                m_ack1 = n1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
